// File: rtl/sudoku_grid_checker.sv
// Scans an N x N sudoku board (N = BOX*BOX) row by row from a synchronous RAM
// and reports solved / empty-cell / conflict status, plus the lowest row tied to a conflict.
module sudoku_grid_checker #(
    parameter int BOX        = 2,
    parameter int DIGIT_W    = 4,
    parameter int CONTINUOUS = 0,
    localparam int N  = BOX * BOX,
    localparam int AW = (N > 1) ? $clog2(N) : 1,
    localparam int RW = N * DIGIT_W
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    output logic [AW-1:0] ram_addr,
    input  logic [RW-1:0] ram_rdata,
    output logic          busy,
    output logic          done,
    output logic          game_complete,
    output logic          has_empty,
    output logic          conflict,
    output logic [AW-1:0] conflict_row
);

    localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(N);
    localparam logic [AW-1:0]      LAST_ROW  = AW'(N - 1);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_EVAL, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d, idx1_q, first_row_q, crow_q;
    logic                vld1_q, busy_q, done_q, gc_q, he_q, cf_q;
    logic                any_empty_q, any_conf_q, enter_scan_s;
    logic [N-1:0]        col_mask_q [N];
    logic [N-1:0]        col_mask_d [N];
    logic [N-1:0]        box_mask_q [N];
    logic [N-1:0]        box_mask_d [N];
    logic [AW-1:0]       col_row_q  [N][N];
    logic [AW-1:0]       col_row_d  [N][N];
    logic [AW-1:0]       box_row_q  [N][N];
    logic [AW-1:0]       box_row_d  [N][N];
    logic [DIGIT_W-1:0]  cell_s     [N];
    logic                row_empty_s, row_conf_s;
    logic [AW-1:0]       cand_s;
    int                  box_s, dig_s;

    for (genvar c = 0; c < N; c++) begin : g_cell
        assign cell_s[c] = ram_rdata[c*DIGIT_W +: DIGIT_W];
    end

    // Next-state and row-address sequencing.
    always_comb begin
        state_d = state_q;
        addr_d  = '0;
        case (state_q)
            S_IDLE:  if (CONTINUOUS != 0 || start) state_d = S_SCAN; else state_d = S_IDLE;
            S_SCAN:  if (addr_q == LAST_ROW) state_d = S_DRAIN; else state_d = S_SCAN;
            S_DRAIN: state_d = S_EVAL;
            S_EVAL:  state_d = S_DONE;
            S_DONE:  if (CONTINUOUS != 0) state_d = S_SCAN; else state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_q == S_SCAN && state_d == S_SCAN) addr_d = addr_q + AW'(1);
        else addr_d = '0;
    end

    assign enter_scan_s = (state_d == S_SCAN) && (state_q != S_SCAN);

    // Per-row checks; each mask bit also remembers the row that first set it,
    // so a column/box repeat can be blamed on the earliest row involved.
    always_comb begin
        col_mask_d  = col_mask_q;
        box_mask_d  = box_mask_q;
        col_row_d   = col_row_q;
        box_row_d   = box_row_q;
        row_empty_s = 1'b0;
        row_conf_s  = 1'b0;
        cand_s      = idx1_q;
        box_s       = 0;
        dig_s       = 0;
        for (int c = 0; c < N; c++) begin
            box_s = (int'(idx1_q) / BOX) * BOX + c / BOX;
            if (cell_s[c] == '0) begin
                row_empty_s = 1'b1;
            end else if (cell_s[c] > MAX_DIGIT) begin
                row_conf_s = 1'b1;
            end else begin
                dig_s = int'(cell_s[c]) - 1;
                if (col_mask_q[c][dig_s]) begin
                    row_conf_s = 1'b1;
                    if (col_row_q[c][dig_s] < cand_s) cand_s = col_row_q[c][dig_s];
                    else cand_s = cand_s;
                end else begin
                    col_mask_d[c][dig_s] = 1'b1;
                    col_row_d[c][dig_s]  = idx1_q;
                end
                if (box_mask_q[box_s][dig_s]) begin
                    row_conf_s = 1'b1;
                    if (box_row_q[box_s][dig_s] < cand_s) cand_s = box_row_q[box_s][dig_s];
                    else cand_s = cand_s;
                end else begin
                    box_mask_d[box_s][dig_s] = 1'b1;
                    box_row_d[box_s][dig_s]  = idx1_q;
                end
            end
            // A same-row repeat also covers two equal cells sharing a box.
            for (int c2 = c + 1; c2 < N; c2++) begin
                if (cell_s[c] != '0 && cell_s[c] == cell_s[c2]) row_conf_s = 1'b1;
                else row_conf_s = row_conf_s;
            end
        end
    end

    // Column and box mask accumulators.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < N; i++) begin
                col_mask_q[i] <= '0;
                box_mask_q[i] <= '0;
                for (int j = 0; j < N; j++) begin
                    col_row_q[i][j] <= '0;
                    box_row_q[i][j] <= '0;
                end
            end
        end else if (enter_scan_s) begin
            for (int i = 0; i < N; i++) begin
                col_mask_q[i] <= '0;
                box_mask_q[i] <= '0;
                for (int j = 0; j < N; j++) begin
                    col_row_q[i][j] <= '0;
                    box_row_q[i][j] <= '0;
                end
            end
        end else if (vld1_q) begin
            col_mask_q <= col_mask_d;
            box_mask_q <= box_mask_d;
            col_row_q  <= col_row_d;
            box_row_q  <= box_row_d;
        end
    end

    // FSM state, read pipeline, sticky flags and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            idx1_q      <= '0;
            vld1_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            gc_q        <= 1'b0;
            he_q        <= 1'b0;
            cf_q        <= 1'b0;
            crow_q      <= '0;
            any_empty_q <= 1'b0;
            any_conf_q  <= 1'b0;
            first_row_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            vld1_q  <= (state_q == S_SCAN);
            idx1_q  <= addr_q;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                gc_q   <= !any_empty_q && !any_conf_q;
                he_q   <= any_empty_q;
                cf_q   <= any_conf_q;
                crow_q <= any_conf_q ? first_row_q : '0;
            end
            if (enter_scan_s) begin
                any_empty_q <= 1'b0;
                any_conf_q  <= 1'b0;
                first_row_q <= '0;
            end else if (vld1_q) begin
                any_empty_q <= any_empty_q | row_empty_s;
                any_conf_q  <= any_conf_q | row_conf_s;
                if (row_conf_s && !any_conf_q) first_row_q <= cand_s;
            end
        end
    end

    assign ram_addr      = addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign game_complete = gc_q;
    assign has_empty     = he_q;
    assign conflict      = cf_q;
    assign conflict_row  = crow_q;

endmodule

// File: tb/tb_sudoku_grid_checker.sv
// Directed bench for sudoku_grid_checker: 4x4 one-shot, 4x4 continuous and 9x9 instances
// with behavioural synchronous RAMs and a queue of expected scan results.
module tb_sudoku_grid_checker;

    typedef struct packed {
        logic       gc;
        logic       he;
        logic       cf;
        logic [3:0] row;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_chk  = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0;
    logic [1:0]  addr_a, crow_a;
    logic [15:0] rdata_a = '0;
    logic        busy_a, done_a, gc_a, he_a, cf_a;
    logic [15:0] ram_a [4];

    logic        start_b = 1'b1;
    logic [1:0]  addr_b, crow_b;
    logic [15:0] rdata_b = '0;
    logic        busy_b, done_b, gc_b, he_b, cf_b;
    logic [15:0] ram_b [4];

    logic        start_c = 1'b0;
    logic [3:0]  addr_c, crow_c;
    logic [35:0] rdata_c = '0;
    logic        busy_c, done_c, gc_c, he_c, cf_c;
    logic [35:0] ram_c [9];

    always @(posedge clk) rdata_a <= ram_a[addr_a];
    always @(posedge clk) rdata_b <= ram_b[addr_b];
    always @(posedge clk) rdata_c <= (addr_c < 4'd9) ? ram_c[addr_c] : 36'd0;

    sudoku_grid_checker #(.BOX(2), .DIGIT_W(4), .CONTINUOUS(0)) dut_a (
        .CLK(clk), .RST(rst_n), .start(start_a), .ram_addr(addr_a), .ram_rdata(rdata_a),
        .busy(busy_a), .done(done_a), .game_complete(gc_a), .has_empty(he_a),
        .conflict(cf_a), .conflict_row(crow_a));

    sudoku_grid_checker #(.BOX(2), .DIGIT_W(4), .CONTINUOUS(1)) dut_b (
        .CLK(clk), .RST(rst_n), .start(start_b), .ram_addr(addr_b), .ram_rdata(rdata_b),
        .busy(busy_b), .done(done_b), .game_complete(gc_b), .has_empty(he_b),
        .conflict(cf_b), .conflict_row(crow_b));

    sudoku_grid_checker #(.BOX(3), .DIGIT_W(4), .CONTINUOUS(0)) dut_c (
        .CLK(clk), .RST(rst_n), .start(start_c), .ram_addr(addr_c), .ram_rdata(rdata_c),
        .busy(busy_c), .done(done_c), .game_complete(gc_c), .has_empty(he_c),
        .conflict(cf_c), .conflict_row(crow_c));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input exp_t got);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, " game_complete"}, 64'(got.gc),  64'(e.gc));
            check({tag, " has_empty"},     64'(got.he),  64'(e.he));
            check({tag, " conflict"},      64'(got.cf),  64'(e.cf));
            check({tag, " conflict_row"},  64'(got.row), 64'(e.row));
        end
    endtask

    // One-shot scan on instance a; optionally pokes start mid-scan (must be ignored).
    task automatic run_a(input string tag, input exp_t e, input bit poke);
        int lat;
        sb_q.push_back(e);
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check({tag, " ram_addr"}, 64'(addr_a), 64'(k));
            check({tag, " busy"}, 64'(busy_a), 64'd1);
            if (poke && k == 2) start_a = 1'b1;
            else start_a = 1'b0;
            @(negedge clk);
        end
        start_a = 1'b0;
        lat = 4;
        while (done_a !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd7);
        check_status(tag, '{gc: gc_a, he: he_a, cf: cf_a, row: 4'(crow_a)});
        @(negedge clk);
        check({tag, " done width"}, 64'(done_a), 64'd0);
        check({tag, " busy after"}, 64'(busy_a), 64'd0);
    endtask

    initial begin
        int   lat;
        int   gap;
        bit   busy_all;
        bit   done_seen;
        int   v;
        ram_a[0] = 16'h4321; ram_a[1] = 16'h2143; ram_a[2] = 16'h3412; ram_a[3] = 16'h1234;
        ram_b[0] = 16'h4321; ram_b[1] = 16'h2143; ram_b[2] = 16'h3412; ram_b[3] = 16'h1234;
        for (int r = 0; r < 9; r++) begin
            ram_c[r] = '0;
            for (int c = 0; c < 9; c++) begin
                v = ((r * 3 + r / 3 + c) % 9) + 1;
                ram_c[r][c*4 +: 4] = 4'(v);
            end
        end

        #12;
        check("reset ram_addr", 64'(addr_a), 64'd0);
        check("reset busy", 64'(busy_a), 64'd0);
        check("reset done", 64'(done_a), 64'd0);
        check("reset status", {gc_a, he_a, cf_a, crow_a}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        run_a("solved", '{gc: 1'b1, he: 1'b0, cf: 1'b0, row: 4'd0}, 1'b0);
        ram_a[2] = 16'h3402;
        run_a("empty", '{gc: 1'b0, he: 1'b1, cf: 1'b0, row: 4'd0}, 1'b0);
        ram_a[2] = 16'h3412; ram_a[3] = 16'h2134;
        run_a("coldup", '{gc: 1'b0, he: 1'b0, cf: 1'b1, row: 4'd1}, 1'b0);
        ram_a[3] = 16'h1234;
        run_a("fixed", '{gc: 1'b1, he: 1'b0, cf: 1'b0, row: 4'd0}, 1'b0);
        ram_a[0] = 16'h4325;
        run_a("range", '{gc: 1'b0, he: 1'b0, cf: 1'b1, row: 4'd0}, 1'b0);
        ram_a[0] = 16'h4321; ram_a[1] = 16'h2243;
        run_a("rowdup", '{gc: 1'b0, he: 1'b0, cf: 1'b1, row: 4'd1}, 1'b0);
        ram_a[1] = 16'h2143;
        run_a("poke", '{gc: 1'b1, he: 1'b0, cf: 1'b0, row: 4'd0}, 1'b1);

        // Reset in the middle of a scan.
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst busy", 64'(busy_a), 64'd0);
        check("midrst ram_addr", 64'(addr_a), 64'd0);
        check("midrst status", {done_a, gc_a, he_a, cf_a, crow_a}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        done_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_a === 1'b1) done_seen = 1'b1;
        end
        check("midrst no done", 64'(done_seen), 64'd0);
        run_a("after rst", '{gc: 1'b1, he: 1'b0, cf: 1'b0, row: 4'd0}, 1'b0);

        // Continuous instance: start held high throughout.
        lat = 0;
        while (done_b !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("cont first done", 64'(done_b), 64'd1);
        for (int p = 0; p < 2; p++) begin
            if (p == 1) begin
                ram_b[1] = 16'h2134;
                sb_q.push_back('{gc: 1'b0, he: 1'b0, cf: 1'b1, row: 4'd1});
            end else begin
                sb_q.push_back('{gc: 1'b1, he: 1'b0, cf: 1'b0, row: 4'd0});
            end
            gap = 0;
            busy_all = 1'b1;
            do begin
                @(negedge clk);
                gap++;
                busy_all = busy_all & (busy_b === 1'b1);
            end while (done_b !== 1'b1 && gap < 20);
            check("cont period", 64'(gap), 64'd7);
            check("cont busy", 64'(busy_all), 64'd1);
            check_status("cont", '{gc: gc_b, he: he_b, cf: cf_b, row: 4'(crow_b)});
        end

        // 9x9 board.
        sb_q.push_back('{gc: 1'b1, he: 1'b0, cf: 1'b0, row: 4'd0});
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check("9x9 ram_addr", 64'(addr_c), 64'(k));
            @(negedge clk);
        end
        lat = 9;
        while (done_c !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("9x9 latency", 64'(lat), 64'd12);
        check_status("9x9", '{gc: gc_c, he: he_c, cf: cf_c, row: crow_c});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
